// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer: synchroniser depth, tick presets and a
// counter-width helper.
package debounce_pkg;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned TICK_DIV_BOARD = 100_000;
    localparam int unsigned TICK_DIV_SIM   = 4;

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button-conditioner bundle: raw inputs towards the debouncer, clean levels/pulses back.
interface btn_debounce_multi_if #(
    parameter int unsigned CH = 4
) ();

    logic [CH-1:0] i_btn;
    logic [CH-1:0] o_level;
    logic [CH-1:0] o_rise;
    logic [CH-1:0] o_fall;
    logic [CH-1:0] o_repeat;
    logic          o_tick;

    modport master (
        output i_btn,
        input  o_level, o_rise, o_fall, o_repeat, o_tick
    );

    modport slave (
        input  i_btn,
        output o_level, o_rise, o_fall, o_repeat, o_tick
    );

endinterface

// File: rtl/debounce_cell.sv
// One debounced channel: 2-FF synchroniser, stable counter, level/edge registers.
// Hold-to-repeat logic is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int unsigned CNT_W = cnt_width(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   accept;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign accept = tick && (sync != level_q) && (cnt_q == CNT_W'(STABLE_TICKS - 1));

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            if (sync == level_q || accept) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (accept) begin
            level_d = sync;
            rise_d  = sync;
            fall_d  = ~sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned RATE_W = cnt_width(REPEAT_RATE);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              rpt_q, rpt_d;

    // hold saturates at REPEAT_DELAY; rate then paces the later pulses
    always_comb begin
        hold_d = hold_q;
        rate_d = rate_q;
        rpt_d  = 1'b0;
        if (!level_q || fall_d) begin
            hold_d = '0;
            rate_d = '0;
        end else if (tick) begin
            if (hold_q != HOLD_W'(REPEAT_DELAY)) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_W'(REPEAT_DELAY - 1)) begin
                    rpt_d  = 1'b1;
                    rate_d = '0;
                end
            end else if (rate_q == RATE_W'(REPEAT_RATE - 1)) begin
                rpt_d  = 1'b1;
                rate_d = '0;
            end else begin
                rate_d = rate_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            rate_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rate_q <= rate_d;
            rpt_q  <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: one shared sample-tick prescaler feeding CH debounce cells.
// Define DEBOUNCE_REPEAT_EN to add hold-to-repeat pulses (REPEAT_DELAY / REPEAT_RATE).
module btn_debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CH           = 4,
    parameter int unsigned TICK_DIV     = TICK_DIV_BOARD,
    parameter int unsigned STABLE_TICKS = 4
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
`endif
) (
    input logic                clk,
    input logic                reset_n,
    btn_debounce_multi_if.slave bus
);

    localparam int unsigned DIV_W = cnt_width(TICK_DIV);

    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_W'(TICK_DIV - 1));

    // tick is registered so it is high for the clk after the wrap cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_wrap ? '0 : div_q + 1'b1;
            tick_q <= div_wrap;
        end
    end

    assign bus.o_tick = tick_q;

    for (genvar i = 0; i < CH; i++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS)
`ifdef DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick_q),
            .btn     (bus.i_btn[i]),
            .level   (bus.o_level[i]),
            .rise    (bus.o_rise[i]),
            .fall    (bus.o_fall[i]),
            .rpt     (bus.o_repeat[i])
        );
    end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner: synchronises CH asynchronous button inputs, debounces each against a shared slow tick, and emits a clean level plus single-cycle press/release pulses per channel. It is the successor to the single-channel, press-only debouncer and sits between the board pins and the UART/control FSMs. An optional compile-time feature adds hold-to-repeat pulses.

## Interface
- CH, 4: number of independent button channels (≥1)
- TICK_DIV, 100_000: clk cycles per sample tick (1 kHz at 100 MHz; ≥2)
- STABLE_TICKS, 4: consecutive ticks a new value must persist before acceptance (≥1)
- REPEAT_DELAY, 500: ticks held before the first repeat pulse (≥1; macro only)
- REPEAT_RATE, 100: ticks between later repeat pulses (≥1; macro only)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_btn  in  CH  raw button inputs, asynchronous, active-high
- o_level  out  CH  debounced level per channel
- o_rise  out  CH  one-clk pulse on accepted press
- o_fall  out  CH  one-clk pulse on accepted release
- o_repeat  out  CH  one-clk auto-repeat pulse (constant 0 without macro)
- o_tick  out  1  sample tick, one clk wide, for downstream reuse

## Operation
- Reset (reset_n=0, asynchronous): synchroniser FFs, prescaler, all channel counters and all outputs cleared to 0.
- Synchroniser: 2 FF stages per channel; the output sync[i] lags i_btn[i] by 2 clk.
- Prescaler: counter 0..TICK_DIV-1 wraps; o_tick=1 for the clk following the cycle where the counter equals TICK_DIV-1. Shared by all channels.
- Per channel, on clk edges where o_tick=1:
  - sync==o_level: stable counter ← 0.
  - sync!=o_level, counter < STABLE_TICKS-1: counter+1.
  - sync!=o_level, counter == STABLE_TICKS-1: o_level ← sync, counter ← 0, and o_rise or o_fall (matching direction) ← 1 on the same edge.
- o_rise/o_fall are cleared on the next clk edge (exactly one clk wide); both never assert together on one channel.
- A single mismatching sample followed by a matching one resets the count, so bounces shorter than STABLE_TICKS ticks produce no output activity.
- Counter width is $clog2(STABLE_TICKS), with a minimum of 1. The counter never exceeds STABLE_TICKS-1.
- Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle.

## Timing
- Acceptance latency from an i_btn edge to the o_level update: min 3+(STABLE_TICKS-1)·TICK_DIV clk, max 2+STABLE_TICKS·TICK_DIV clk.
- o_rise/o_fall are coincident with the o_level change.
- o_tick asserts for 1 clk in every TICK_DIV clk, with the first assertion TICK_DIV clk after reset release.
- Reset mid-count: all outputs go to 0 immediately. After release, no pulse is emitted unless a full new acceptance occurs. A held button after reset yields o_rise once accepted.

## Configuration
- DEBOUNCE_REPEAT_EN defined: each channel has a hold counter of width $clog2(REPEAT_DELAY+1).
  - The hold counter clears when o_level=0.
  - While o_level=1, it counts ticks.
  - o_repeat[i] pulses for 1 clk on the tick that completes REPEAT_DELAY ticks after o_rise, then every REPEAT_RATE ticks until release.
  - The counter saturates and never wraps into a false pulse. Release clears it in the same cycle as o_fall.
- Not defined: no hold counters are synthesised and o_repeat is tied to 0.

## Structure
- Package debounce_pkg: SYNC_STAGES=2 and the default tick constants for board and simulation (TICK_DIV_BOARD=100_000, TICK_DIV_SIM=4).
- Sub-module debounce_cell: one channel holding the synchroniser, stable counter, level/edge registers, and the optional repeat logic. The top instantiates the prescaler once and generates CH cells.

## Test plan
- Reset: reset_n=0 with i_btn=4'hF, then release → all outputs 0; o_level=4'hF after acceptance, with o_rise=4'hF in one cycle.
- Clean press ch0 (TICK_DIV=4, STABLE_TICKS=3) → o_level[0] rises 11–14 clk after the edge, with o_rise[0] high for exactly 1 clk.
- Bounce ch1: toggle every 3 clk for 40 clk, then hold 1 → exactly one o_rise[1] and zero o_fall[1].
- Simultaneous: ch2 press and ch3 release on the same clk → o_rise[2] and o_fall[3] in the same cycle.
- Reset mid-count: assert reset_n=0 after 2 of 3 ticks, then release with input low → no pulses and o_level=0.
- Repeat (DEBOUNCE_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2): hold ch0 → o_repeat[0] on ticks 5, 7, 9 after o_rise; stops on release. Without the macro, o_repeat stays 0.
